frame_serializer: RTL
=====================

Name: frame_serializer

Overview:
- Downstream neighbour of the framing byte buffer. Consumes its byte stream (each byte held 8 cycles) and its `indicator` pulses. Emits one serial bit per clock.
- Frame on the wire: preamble of 0x55 bytes, then SFD 0xD5, then payload bits MSB first, then a CRC-16/CCITT trailer.
- Output feeds the line coder.

Parameters:
- PRE_LEN, 80, length of the left-padding window in cycles; multiple of 8 and ≥16; must equal the upstream left-pad length.
- PRE_BYTE, 8'h55, preamble fill byte, sent (PRE_LEN/8 − 1) times.
- SFD, 8'hD5, start-of-frame delimiter; last byte of the preamble window.
- BYTE_CYCLES, 8, cycles each input byte is held (one bit per cycle).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- din  in  8  byte from upstream buffer; stable for BYTE_CYCLES cycles per byte
- indicator  in  1  one-cycle pulse: first pulse starts left padding, second pulse starts right padding
- sout  out  1  serial bit
- sout_valid  out  1  sout carries a frame bit
- frame_start  out  1  pulse coincident with first preamble bit on sout
- frame_end  out  1  pulse coincident with last CRC bit on sout
- err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset state: IDLE; counters 0; CRC reg 16'hFFFF; sout, sout_valid, frame_start, frame_end, err all 0.
- Reset is asynchronous and can abort mid-frame. No bits are output afterwards until a new indicator arrives.
- FSM states: IDLE, PREAMBLE, DATA, CRC.
- Each cycle a candidate bit is produced. It moves to a stage register, then to the output register, so latency is 2 cycles: a candidate in cycle c appears on sout in cycle c+2.
- IDLE:
  - No candidate.
  - indicator → PREAMBLE, with the indicator cycle as preamble bit 0.
- PREAMBLE (PRE_LEN cycles, counter 0..PRE_LEN−1):
  - Candidate for bit k = PRE_BYTE[7−(k mod 8)] for the first PRE_LEN−8 cycles, then SFD[7..0].
  - After the last bit → DATA with phase 0.
- DATA:
  - 3-bit phase p cycles 0..7 freely; candidate = din[7−p].
  - indicator → CRC. The stage bit already captured in that cycle is the upstream one-cycle empty slot. It is discarded: the output register loads sout_valid=0 and the CRC does not absorb it.
  - Payload bytes of value 0x00 are never treated as end of frame. Only indicator ends DATA.
- CRC bookkeeping:
  - Polynomial 0x1021, init 0xFFFF, no final XOR, MSB-first bit-serial.
  - The CRC absorbs the stage bit at each clock edge while the stage holds a DATA bit and indicator is low.
  - It reinitialises to 0xFFFF on entry to PREAMBLE.
- CRC state (16 cycles):
  - Cycle 0 candidate = crc[15]; the remaining CRC bits are shifted out MSB first.
  - After bit 15 → IDLE.
  - frame_end is asserted with the sout bit of CRC bit 15.
- frame_start is asserted with sout of preamble bit 0.
- sout_valid is high for every preamble, payload and CRC bit. It is low for the discarded slot and in IDLE.
- Violations (err pulses one cycle after the indicator):
  - indicator in PREAMBLE → preamble restarts at bit 0.
  - indicator in CRC → trailer aborted, no frame_end, new PREAMBLE starts.
  - In both cases the CRC reinitialises.
- Empty payload (indicator in DATA on phase 0 before any full byte): CRC is sent as 0xFFFF and no err.

Decomposition:
- Package frame_pkg holds:
  - state enum;
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - default PRE_BYTE and SFD;
  - CRC_LEN=16, which the upstream right-pad length must equal.
- Sub-module crc16_ccitt_serial: inputs clk, reset_n, init, en, bit_in; output crc[15:0]; one bit per enabled cycle.

Test Plan:
- Golden frame:
  - Stimulus: indicator at T, bytes "123456789" (0x31..0x39) from T+80, 8 cycles each, empty slot at E=T+152, indicator at E+1.
  - Response: sout T+2.. = 9×0x55, 0xD5, the 72 payload bits, valid gap at E+2, 0x29B1 on E+3..E+18; frame_start at T+2; frame_end at E+18.
- Zero payload:
  - Stimulus: bytes 0x00,0x00.
  - Response: 16 payload zeros all valid; frame not ended early; trailer = CRC of two zero bytes from a software model.
- Back-to-back frames:
  - Stimulus: second indicator 1 cycle after the first frame returns to IDLE.
  - Response: second preamble contiguous; CRC restarts at 0xFFFF; no err.
- Spurious indicator:
  - Stimulus: indicator at preamble bit 40.
  - Response: err pulse; preamble restarts; full 80-bit preamble follows.
- Reset mid-payload:
  - Stimulus: reset_n low at payload bit 20.
  - Response: all outputs 0 immediately; sout_valid stays 0 until the next indicator; the next frame is correct.
- Empty payload:
  - Stimulus: indicator in DATA at phase 0 with no complete byte.
  - Response: trailer = 0xFFFF; frame_end asserted; no err.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the serial framer: FSM states, CRC-16/CCITT
// parameters and the default preamble/SFD bytes.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_CRC      = 2'd3
    } state_e;

    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [7:0]  DEF_PRE_BYTE = 8'h55;
    localparam logic [7:0]  DEF_SFD      = 8'hD5;

    // Trailer length; the upstream right-pad window must match it.
    localparam int unsigned CRC_LEN = 16;

    // One MSB-first step of the CCITT polynomial, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT accumulator: one bit per enabled cycle, init wins
// over enable so a frame restart always starts from a clean register.
module crc16_ccitt_serial
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/frame_serializer.sv
// Serialises the framing buffer's byte stream into preamble, SFD, payload and
// CRC-16 trailer, one bit per clock, through a two-deep output pipeline.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no frame; waiting for the opening indicator
// PREAMBLE | PRE_LEN bits of fill byte followed by SFD (cnt_q = bit index)
// DATA     | payload bits MSB first from din; phase_q = bit within byte
// CRC      | trailer bits of the frozen CRC register (cnt_q = bit index)
module frame_serializer
    import frame_pkg::*;
#(
    parameter int unsigned PRE_LEN     = 80,
    parameter logic [7:0]  PRE_BYTE    = DEF_PRE_BYTE,
    parameter logic [7:0]  SFD         = DEF_SFD,
    parameter int unsigned BYTE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] din,
    input  logic       indicator,
    output logic       sout,
    output logic       sout_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(PRE_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       phase_q, phase_d;

    logic cand_bit, cand_valid, cand_data, cand_start, cand_end;

    logic stage_bit_q, stage_bit_d;
    logic stage_valid_q, stage_valid_d;
    logic stage_data_q, stage_data_d;
    logic stage_start_q, stage_start_d;
    logic stage_end_q, stage_end_d;

    logic sout_q, sout_d;
    logic sout_valid_q, sout_valid_d;
    logic frame_start_q, frame_start_d;
    logic frame_end_q, frame_end_d;
    logic err_q, err_d;

    logic        restart;
    logic        drop_slot;
    logic        crc_en;
    logic [15:0] crc;

    // Any indicator outside DATA opens a fresh preamble, legal or not.
    assign restart = indicator && (state_q != ST_DATA);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        cand_bit   = 1'b0;
        cand_valid = 1'b0;
        cand_data  = 1'b0;
        cand_start = 1'b0;
        cand_end   = 1'b0;
        err_d      = indicator && ((state_q == ST_PREAMBLE) || (state_q == ST_CRC));

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_PREAMBLE: begin
                cand_valid = 1'b1;
                cand_bit   = (cnt_q < CNT_W'(PRE_LEN - 8)) ? PRE_BYTE[~cnt_q[2:0]]
                                                           : SFD[~cnt_q[2:0]];
                if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    phase_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                cand_valid = 1'b1;
                if (indicator) begin
                    cand_bit = crc[15];
                    state_d  = ST_CRC;
                    cnt_d    = CNT_W'(1);
                end else begin
                    cand_bit  = din[~phase_q];
                    cand_data = 1'b1;
                    phase_d   = (phase_q == 3'(BYTE_CYCLES - 1)) ? 3'd0 : phase_q + 3'd1;
                end
            end
            ST_CRC: begin
                cand_valid = 1'b1;
                cand_bit   = crc[~cnt_q[3:0]];
                if (cnt_q == CNT_W'(CRC_LEN - 1)) begin
                    cand_end = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (restart) begin
            cand_valid = 1'b1;
            cand_bit   = PRE_BYTE[7];
            cand_data  = 1'b0;
            cand_start = 1'b1;
            cand_end   = 1'b0;
            state_d    = ST_PREAMBLE;
            cnt_d      = CNT_W'(1);
        end
    end

    // The stage bit present when DATA sees its closing indicator is the
    // upstream empty slot: it is neither sent nor folded into the CRC.
    assign drop_slot = (state_q == ST_DATA) && indicator && stage_data_q;
    assign crc_en    = stage_data_q && !indicator;

    always_comb begin
        stage_bit_d   = cand_bit;
        stage_valid_d = cand_valid;
        stage_data_d  = cand_data;
        stage_start_d = cand_start;
        stage_end_d   = cand_end;

        sout_valid_d  = stage_valid_q && !drop_slot;
        sout_d        = stage_bit_q && sout_valid_d;
        frame_start_d = stage_start_q;
        frame_end_d   = stage_end_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            phase_q       <= '0;
            stage_bit_q   <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= 1'b0;
            stage_start_q <= 1'b0;
            stage_end_q   <= 1'b0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            stage_bit_q   <= stage_bit_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_start_q <= stage_start_d;
            stage_end_q   <= stage_end_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            err_q         <= err_d;
        end
    end

    crc16_ccitt_serial u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (restart),
        .en      (crc_en),
        .bit_in  (stage_bit_q),
        .crc     (crc)
    );

    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign err         = err_q;

endmodule
